// File: rtl/xfer2ringbuf_nch_pkg.sv
// Shared types and helpers for the multi-channel FIFO-to-ring-buffer transfer stage.
package xfer2ringbuf_nch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam int CNT_W      = 8;
  localparam int DRAIN_W    = 3;
  localparam int UNDERRUN_W = 16;

  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xfer2ringbuf_nch_seq.sv
// Event sequencer: walks the captured channel mask lowest bit first and issues
// NSAMP read requests per channel, pausing whenever the ring buffer is almost full.
module xfer2ringbuf_nch_seq
  import xfer2ringbuf_nch_pkg::*;
#(
  parameter int NCHAN  = 16,
  parameter int NSAMP  = 8,
  parameter int RD_LAT = 1,
  parameter int CHW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jtag_mode,
  input  logic             rdy,
  input  logic             rb_full,
  input  logic [NCHAN-1:0] chan_mask,
  output logic             re,
  output logic [CHW-1:0]   chan,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0]   LAST_SAMP = CNT_W'(NSAMP - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LEN = DRAIN_W'(RD_LAT + 1);
  localparam logic [NCHAN-1:0]   ONE       = NCHAN'(1);

  seq_state_e           state_q, state_d;
  logic [NCHAN-1:0]     mask_q, mask_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [NCHAN-1:0]     mask_clr;

  always_comb begin
    chan = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (mask_q[i]) chan = CHW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    re       = 1'b0;
    mask_clr = mask_q & ~(ONE << chan);
    case (state_q)
      ST_IDLE: begin
        if (rdy && !jtag_mode) begin
          state_d = ST_ARM;
          mask_d  = chan_mask;
          cnt_d   = '0;
        end
      end
      ST_ARM: begin
        state_d = (mask_q == '0) ? ST_DONE : ST_XFER;
      end
      ST_XFER: begin
        re = !rb_full && !jtag_mode;
        if (re) begin
          if (cnt_q == LAST_SAMP) begin
            cnt_d  = '0;
            mask_d = mask_clr;
            if (mask_clr == '0) begin
              state_d = ST_DRAIN;
              drain_d = DRAIN_LEN;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Fixed wait long enough for the last request to reach WREN.
        if (drain_q == '0) state_d = ST_DONE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (jtag_mode) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: rtl/xfer2ringbuf_nch.sv
// Multi-channel transfer stage: reads enabled channel FIFOs in ascending order and
// streams the samples into the ring buffer, with backpressure, underrun count and JTAG override.
module xfer2ringbuf_nch
  import xfer2ringbuf_nch_pkg::*;
#(
  parameter  int NCHAN  = 16,
  parameter  int DW     = 12,
  parameter  int NSAMP  = 8,
  parameter  int RD_LAT = 1,
  localparam int CHW    = chan_width(NCHAN)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  JTAG_MODE,
  input  logic                  J_RD_FIFO,
  input  logic [NCHAN-1:0]      CHAN_MASK,
  input  logic [NCHAN*DW-1:0]   DIN,
  input  logic                  RDY,
  input  logic [NCHAN-1:0]      F_MT,
  input  logic                  RB_FULL,
  output logic [NCHAN-1:0]      RD_ENA,
  output logic                  L1A_RD_EN,
  output logic                  WREN,
  output logic [DW-1:0]         DMUX,
  output logic [CHW-1:0]        DCHAN,
  output logic                  BUSY,
  output logic [UNDERRUN_W-1:0] UNDERRUN_CNT
);

  localparam int               PD  = RD_LAT + 1;
  localparam logic [NCHAN-1:0] ONE = NCHAN'(1);
  localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = '1;

  logic                  re;
  logic [CHW-1:0]        chan;

  logic [NCHAN-1:0]      rd_ena_q, rd_ena_d;
  logic [PD-1:0]         vld_q, vld_d;
  logic [CHW-1:0]        pch_q [PD];
  logic [CHW-1:0]        pch_d [PD];
  logic                  wren_q, wren_d;
  logic [DW-1:0]         dmux_q, dmux_d;
  logic [CHW-1:0]        dchan_q, dchan_d;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;

  xfer2ringbuf_nch_seq #(
    .NCHAN  (NCHAN),
    .NSAMP  (NSAMP),
    .RD_LAT (RD_LAT),
    .CHW    (CHW)
  ) u_seq (
    .clk       (CLK),
    .rst       (RST),
    .jtag_mode (JTAG_MODE),
    .rdy       (RDY),
    .rb_full   (RB_FULL),
    .chan_mask (CHAN_MASK),
    .re        (re),
    .chan      (chan),
    .busy      (BUSY),
    .done      (L1A_RD_EN)
  );

  // The channel index rides alongside each valid bit so a word is always
  // muxed from the FIFO that was actually read, even across channel switches.
  always_comb begin
    rd_ena_d = '0;
    if (JTAG_MODE)  rd_ena_d = {NCHAN{J_RD_FIFO}};
    else if (re)    rd_ena_d = ONE << chan;

    vld_d[0] = re;
    pch_d[0] = chan;
    for (int i = 1; i < PD; i++) begin
      vld_d[i] = vld_q[i-1];
      pch_d[i] = pch_q[i-1];
    end
    if (JTAG_MODE) vld_d = '0;

    wren_d  = vld_q[PD-1] && !JTAG_MODE;
    dmux_d  = dmux_q;
    dchan_d = dchan_q;
    if (vld_q[PD-1]) begin
      dmux_d  = DIN[pch_q[PD-1]*DW +: DW];
      dchan_d = pch_q[PD-1];
    end

    underrun_d = underrun_q;
    if (re && F_MT[chan] && (underrun_q != UNDERRUN_MAX)) begin
      underrun_d = underrun_q + UNDERRUN_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ena_q   <= '0;
      vld_q      <= '0;
      for (int i = 0; i < PD; i++) pch_q[i] <= '0;
      wren_q     <= 1'b0;
      dmux_q     <= '0;
      dchan_q    <= '0;
      underrun_q <= '0;
    end else begin
      rd_ena_q   <= rd_ena_d;
      vld_q      <= vld_d;
      for (int i = 0; i < PD; i++) pch_q[i] <= pch_d[i];
      wren_q     <= wren_d;
      dmux_q     <= dmux_d;
      dchan_q    <= dchan_d;
      underrun_q <= underrun_d;
    end
  end

  assign RD_ENA       = rd_ena_q;
  assign WREN         = wren_q;
  assign DMUX         = dmux_q;
  assign DCHAN        = dchan_q;
  assign UNDERRUN_CNT = underrun_q;

endmodule

// File: tb/tb_xfer2ringbuf_nch.sv
// Scoreboard bench for xfer2ringbuf_nch: a behavioural FIFO bank feeds the DUT and
// expected ring-buffer words are queued per event, then matched by a WREN monitor.
module tb_xfer2ringbuf_nch;

  localparam int NCHAN  = 16;
  localparam int DW     = 12;
  localparam int NSAMP  = 8;
  localparam int RD_LAT = 1;
  localparam int CHW    = 4;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  d;
  } word_t;

  logic                CLK = 1'b0;
  logic                RST, JTAG_MODE, J_RD_FIFO, RDY, RB_FULL;
  logic [NCHAN-1:0]    CHAN_MASK, F_MT, RD_ENA;
  logic [NCHAN*DW-1:0] DIN;
  logic                L1A_RD_EN, WREN, BUSY;
  logic [DW-1:0]       DMUX;
  logic [CHW-1:0]      DCHAN;
  logic [15:0]         UNDERRUN_CNT;

  always #5 CLK = ~CLK;

  xfer2ringbuf_nch #(
    .NCHAN  (NCHAN),
    .DW     (DW),
    .NSAMP  (NSAMP),
    .RD_LAT (RD_LAT)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .JTAG_MODE    (JTAG_MODE),
    .J_RD_FIFO    (J_RD_FIFO),
    .CHAN_MASK    (CHAN_MASK),
    .DIN          (DIN),
    .RDY          (RDY),
    .F_MT         (F_MT),
    .RB_FULL      (RB_FULL),
    .RD_ENA       (RD_ENA),
    .L1A_RD_EN    (L1A_RD_EN),
    .WREN         (WREN),
    .DMUX         (DMUX),
    .DCHAN        (DCHAN),
    .BUSY         (BUSY),
    .UNDERRUN_CNT (UNDERRUN_CNT)
  );

  // Each channel holds an endless ramp tagged with its channel number.
  function automatic logic [DW-1:0] sample_of(input int c, input int n);
    return DW'((c << 8) | (n & 255));
  endfunction

  int            fifo_ptr  [NCHAN] = '{default: 0};
  logic [DW-1:0] fifo_dout [NCHAN] = '{default: '0};

  always @(posedge CLK) begin
    for (int c = 0; c < NCHAN; c++) begin
      if (RD_ENA[c]) begin
        fifo_dout[c] <= sample_of(c, fifo_ptr[c]);
        fifo_ptr[c]  <= fifo_ptr[c] + 1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCHAN; c++) DIN[c*DW +: DW] = fifo_dout[c];
  end

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    wren_count = 0;
  int    l1a_count = 0;
  int    l1a_cyc = 0;
  int    wr_log [$];
  word_t exp_q [$];
  int    model_ptr [NCHAN] = '{default: 0};
  int    exp_under = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    word_t w;
    if (!RST) begin
      if (WREN) begin
        wren_count++;
        wr_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wren: got write ch=%0d data=%0h, expected no write", DCHAN, DMUX);
        end else begin
          w = exp_q.pop_front();
          checkOutput("dchan", 64'(DCHAN), 64'(w.ch));
          checkOutput("dmux", 64'(DMUX), 64'(w.d));
        end
      end
      if (L1A_RD_EN) begin
        l1a_count++;
        l1a_cyc = cyc;
        checkOutput("busy_at_l1a", 64'(BUSY), 64'd1);
      end
    end
  end

  // Reference model: enabled channels ascending, NSAMP consecutive ramp values each.
  task automatic push_event(input logic [NCHAN-1:0] mask, input logic [NCHAN-1:0] fmt);
    word_t w;
    for (int c = 0; c < NCHAN; c++) begin
      if (mask[c]) begin
        for (int s = 0; s < NSAMP; s++) begin
          w.ch = CHW'(c);
          w.d  = sample_of(c, model_ptr[c]);
          exp_q.push_back(w);
          model_ptr[c]++;
        end
        if (fmt[c]) exp_under = (exp_under + NSAMP > 65535) ? 65535 : exp_under + NSAMP;
      end
    end
  endtask

  task automatic resync_model();
    exp_q.delete();
    for (int c = 0; c < NCHAN; c++) model_ptr[c] = fifo_ptr[c];
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_rd_ena"},   64'(RD_ENA), 64'd0);
    checkOutput({tag, "_wren"},     64'(WREN), 64'd0);
    checkOutput({tag, "_l1a"},      64'(L1A_RD_EN), 64'd0);
    checkOutput({tag, "_busy"},     64'(BUSY), 64'd0);
    checkOutput({tag, "_dmux"},     64'(DMUX), 64'd0);
    checkOutput({tag, "_dchan"},    64'(DCHAN), 64'd0);
    checkOutput({tag, "_underrun"}, 64'(UNDERRUN_CNT), 64'd0);
  endtask

  task automatic start_event(input logic [NCHAN-1:0] mask, input logic [NCHAN-1:0] fmt, output int start);
    @(posedge CLK); #1;
    CHAN_MASK = mask;
    F_MT      = fmt;
    RDY       = 1'b1;
    start     = cyc;
    push_event(mask, fmt);
    @(posedge CLK); #1;
    RDY       = 1'b0;
    CHAN_MASK = NCHAN'($urandom);
  endtask

  task automatic applyStimulus(input logic [NCHAN-1:0] mask, input logic [NCHAN-1:0] fmt,
                               input int stall_at, input int stall_pct);
    int start, l1a0, wr0, t, nwords, exp_dur, sw;
    l1a0   = l1a_count;
    wr0    = wren_count;
    nwords = $countones(mask) * NSAMP;
    wr_log.delete();
    start_event(mask, fmt, start);
    t = 0;
    while (l1a_count == l1a0 && t < 4000) begin
      @(posedge CLK); #1;
      t++;
      if (stall_at > 0) RB_FULL = (cyc >= start + stall_at) && (cyc < start + stall_at + 5);
      else              RB_FULL = ($urandom_range(99) < 32'(stall_pct));
    end
    RB_FULL = 1'b0;
    if (t >= 4000) begin
      checks++;
      errors++;
      $display("[TB] FAIL l1a_timeout: got no L1A_RD_EN after %0d cycles, expected one", t);
    end
    repeat (RD_LAT + 3) @(posedge CLK);
    #1;
    checkOutput("l1a_pulses", 64'(l1a_count - l1a0), 64'd1);
    checkOutput("word_count", 64'(wren_count - wr0), 64'(nwords));
    checkOutput("leftover_words", 64'(exp_q.size()), 64'd0);
    checkOutput("underrun_cnt", 64'(UNDERRUN_CNT), 64'(exp_under));
    checkOutput("busy_after", 64'(BUSY), 64'd0);
    if (stall_pct == 0) begin
      exp_dur = (mask == '0) ? 3 : 3 + nwords + RD_LAT + 2;
      if (stall_at > 0) exp_dur += 5;
      checkOutput("event_cycles", 64'(l1a_cyc - start + 1), 64'(exp_dur));
    end
    if (stall_at > 0) begin
      sw = 0;
      foreach (wr_log[i]) begin
        if (wr_log[i] > start + stall_at && wr_log[i] <= start + stall_at + 5) sw++;
      end
      checkOutput("stall_writes", 64'(sw), 64'(RD_LAT + 1));
    end
  endtask

  task automatic wait_words(input int wr0, input int n, input string tag);
    int t;
    t = 0;
    while (wren_count - wr0 < n && t < 1000) begin
      @(posedge CLK); #1;
      t++;
    end
    if (t >= 1000) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d words, expected %0d", tag, wren_count - wr0, n);
    end
  endtask

  task automatic jtag_abort_test();
    int start, l1a0, wr0, jcyc, late;
    logic jprev;
    l1a0 = l1a_count;
    wr0  = wren_count;
    wr_log.delete();
    start_event('1, '0, start);
    wait_words(wr0, 40, "jtag_word40");
    JTAG_MODE = 1'b1;
    J_RD_FIFO = 1'($urandom);
    jcyc      = cyc;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      jprev     = J_RD_FIFO;
      J_RD_FIFO = 1'($urandom);
      @(negedge CLK);
      checkOutput("rd_ena_jtag", 64'(RD_ENA), 64'({NCHAN{jprev}}));
      checkOutput("wren_jtag", 64'(WREN), 64'd0);
    end
    @(posedge CLK); #1;
    JTAG_MODE = 1'b0;
    J_RD_FIFO = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    late = 0;
    foreach (wr_log[i]) if (wr_log[i] >= jcyc + RD_LAT + 2) late++;
    checkOutput("jtag_late_wren", 64'(late), 64'd0);
    checkOutput("jtag_no_l1a", 64'(l1a_count - l1a0), 64'd0);
    checkOutput("jtag_busy", 64'(BUSY), 64'd0);
    checkOutput("jtag_started", 64'(start > 0), 64'd1);
    resync_model();
  endtask

  task automatic reset_abort_test();
    int start, l1a0, wr0, rcyc, late;
    l1a0 = l1a_count;
    wr0  = wren_count;
    wr_log.delete();
    start_event('1, NCHAN'(1) << 2, start);
    wait_words(wr0, 20, "rst_word20");
    RST  = 1'b1;
    rcyc = cyc;
    @(posedge CLK); #1;
    RST  = 1'b0;
    exp_under = 0;
    @(negedge CLK);
    check_all_zero("rst_mid");
    repeat (10) @(posedge CLK);
    #1;
    late = 0;
    foreach (wr_log[i]) if (wr_log[i] > rcyc) late++;
    checkOutput("rst_late_wren", 64'(late), 64'd0);
    checkOutput("rst_no_l1a", 64'(l1a_count - l1a0), 64'd0);
    checkOutput("rst_started", 64'(start > 0), 64'd1);
    resync_model();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NCHAN-1:0] m, f;
    RST       = 1'b1;
    JTAG_MODE = 1'b0;
    J_RD_FIFO = 1'b0;
    RDY       = 1'b0;
    RB_FULL   = 1'b0;
    CHAN_MASK = '0;
    F_MT      = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_all_zero("reset");

    $display("[TB] full mask, ramps");
    applyStimulus(16'hFFFF, 16'h0000, 0, 0);
    $display("[TB] sparse mask and empty mask");
    applyStimulus(16'h0101, 16'h0000, 0, 0);
    applyStimulus(16'h0000, 16'h0000, 0, 0);
    $display("[TB] ring buffer stall in channel 3");
    applyStimulus(16'hFFFF, 16'h0000, 30, 0);
    $display("[TB] underrun on channel 5");
    applyStimulus(16'hFFFF, 16'h0020, 0, 0);
    $display("[TB] JTAG abort");
    jtag_abort_test();
    applyStimulus(16'hFFFF, 16'h0000, 0, 0);
    $display("[TB] reset abort");
    reset_abort_test();
    applyStimulus(16'hFFFF, 16'h0000, 0, 0);

    $display("[TB] randomized events");
    for (int e = 0; e < 10; e++) begin
      m = NCHAN'($urandom);
      if (e % 3 == 0) m = m & NCHAN'($urandom);
      f = NCHAN'($urandom) & NCHAN'($urandom) & NCHAN'($urandom);
      applyStimulus(m, f, 0, (e % 2 == 1) ? 30 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
